// File: rtl/dsp_run_controller_if.sv
// Host/processor-facing signal bundle for dsp_run_controller.
// slave = controller side, master = host/processor side.
interface dsp_run_controller_if;
  logic        load_valid;
  logic [11:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        run_req;
  logic        busy;
  logic        proc_reset;
  logic        proc_start;
  logic [7:0]  proc_pc;
  logic [11:0] proc_mem_out;
  logic [7:0]  proc_acc;
  logic        proc_data_ready;
  logic        result_valid;
  logic [7:0]  result_data;
  logic        result_ready;
  logic        timeout_err;
  logic        err_clr;
  logic [8:0]  load_count;

  modport slave (
    input  load_valid, load_data, load_last, run_req, proc_pc, proc_acc,
           proc_data_ready, result_ready, err_clr,
    output load_ready, busy, proc_reset, proc_start, proc_mem_out,
           result_valid, result_data, timeout_err, load_count
  );

  modport master (
    output load_valid, load_data, load_last, run_req, proc_pc, proc_acc,
           proc_data_ready, result_ready, err_clr,
    input  load_ready, busy, proc_reset, proc_start, proc_mem_out,
           result_valid, result_data, timeout_err, load_count
  );
endinterface

// File: rtl/dsp_run_controller.sv
// Loads a program into local RAM, runs the attached processor under a watchdog,
// and hands the final accumulator to a consumer. All outputs are registered.
module dsp_run_controller #(
  parameter int WDOG_CYCLES = 1024,
  parameter int PROG_DEPTH  = 256
) (
  input  logic clk,
  input  logic reset,
  dsp_run_controller_if.slave bus
);
  localparam int          AW        = $clog2(PROG_DEPTH);
  localparam logic [8:0]  DEPTH     = 9'(PROG_DEPTH);
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, DONE, FAULT} state_t;

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        closed_q, closed_d;
  logic [15:0] wdog_q, wdog_d;
  logic        rv_q, rv_d;
  logic [7:0]  rd_q, rd_d;
  logic        to_q, to_d;
  logic        lr_q, lr_d;
  logic        busy_q, busy_d;
  logic        prst_q, prst_d;
  logic        pstart_q, pstart_d;
  logic [11:0] mem_q;
  logic        accept;
  logic [AW-1:0] wr_addr;

  logic [11:0] ram [0:PROG_DEPTH-1];

  // load_ready is only ever high in IDLE, so it alone qualifies acceptance
  assign accept  = bus.load_valid & lr_q;
  assign wr_addr = closed_q ? '0 : cnt_q[AW-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    closed_d = closed_q;
    wdog_d   = wdog_q;
    rv_d     = rv_q;
    rd_d     = rd_q;
    to_d     = to_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (closed_q) begin
            cnt_d    = 9'd1;
            closed_d = bus.load_last || (DEPTH == 9'd1);
          end else begin
            cnt_d    = cnt_q + 9'd1;
            closed_d = bus.load_last || (cnt_q + 9'd1 == DEPTH);
          end
        end else if (bus.run_req && closed_q) begin
          state_d = PRIME;
        end
      end
      PRIME: begin
        state_d = RUN;
        wdog_d  = '0;
      end
      RUN: begin
        // completion takes priority over the watchdog terminal count
        if (bus.proc_data_ready) begin
          rd_d    = bus.proc_acc;
          rv_d    = 1'b1;
          state_d = DONE;
        end else if (wdog_q == WDOG_LAST) begin
          to_d    = 1'b1;
          state_d = FAULT;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      DONE: begin
        if (bus.result_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      FAULT: begin
        if (bus.err_clr) begin
          to_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d == PRIME) || (state_d == RUN);
    prst_d   = (state_d != RUN);
    pstart_d = (state_d == PRIME);
    lr_d     = (state_d == IDLE) && ((cnt_d < DEPTH) || closed_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      closed_q <= 1'b0;
      wdog_q   <= '0;
      rv_q     <= 1'b0;
      rd_q     <= '0;
      to_q     <= 1'b0;
      lr_q     <= 1'b1;
      busy_q   <= 1'b0;
      prst_q   <= 1'b1;
      pstart_q <= 1'b0;
      mem_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      closed_q <= closed_d;
      wdog_q   <= wdog_d;
      rv_q     <= rv_d;
      rd_q     <= rd_d;
      to_q     <= to_d;
      lr_q     <= lr_d;
      busy_q   <= busy_d;
      prst_q   <= prst_d;
      pstart_q <= pstart_d;
      mem_q    <= ram[bus.proc_pc[AW-1:0]];
    end
  end

  // program storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (accept && !reset) ram[wr_addr] <= bus.load_data;
  end

  assign bus.load_ready   = lr_q;
  assign bus.busy         = busy_q;
  assign bus.proc_reset   = prst_q;
  assign bus.proc_start   = pstart_q;
  assign bus.proc_mem_out = mem_q;
  assign bus.result_valid = rv_q;
  assign bus.result_data  = rd_q;
  assign bus.timeout_err  = to_q;
  assign bus.load_count   = cnt_q;
endmodule
